mem_wb_stage: RTL and testbench

Back end of the EXE interface: consumes EXE-stage results and completes each instruction.
- Performs the data-memory access for loads/stores over a req/ack bus, with wait states and a timeout.
- Writes the register file and issues branch redirects to the PC system.
- Registers every output; back-pressures EXE with ex_ready while a memory access is outstanding.

---
 rtl/proc_pkg.sv | 12 +
 rtl/mem_wb_timer.sv | 28 ++
 rtl/mem_wb_stage.sv | 135 +++++++++++++
 tb/tb_mem_wb_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the memory/write-back stage.
`timescale 1ns/1ps
package proc_pkg;
  localparam int DW          = 32;
  localparam int AW_RF       = 4;
  localparam int LINK_OFFSET = 4;

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } state_t;
endpackage

// File: rtl/mem_wb_timer.sv
// Wait-state counter for an outstanding memory access; expire marks the last allowed cycle.
`timescale 1ns/1ps
module mem_wb_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  assign expire = (count == CW'(LIMIT - 1));

  // Count cycles without ack; restart whenever a new access begins, saturate at expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// Memory access and register write-back stage: completes EXE results, performs
// loads/stores over a req/ack bus with timeout, writes the RF and redirects branches.
// Handshake: a transfer from EXE happens on a rising clk edge where ex_valid and
// ex_ready are both 1; ex_ready is 0 for the whole of an outstanding memory access.
`timescale 1ns/1ps
module mem_wb_stage #(
  parameter int DW          = proc_pkg::DW,
  parameter int AW_RF       = proc_pkg::AW_RF,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [DW-1:0]    exe_out,
  input  logic             z_flag,
  input  logic [DW-1:0]    pc_in,
  input  logic             is_branch,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             needs_wb,
  input  logic [DW-1:0]    store_data,
  input  logic [AW_RF-1:0] wb_addr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [DW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ack,
  output logic             rf_we,
  output logic [AW_RF-1:0] rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic             br_taken,
  output logic [DW-1:0]    br_target,
  output logic             mem_err,
  output proc_pkg::state_t fsm_state
);
  import proc_pkg::*;

  state_t           state, state_next;
  logic             accept, mem_op, misaligned, start_mem, expire;
  logic             pend_load_wb;
  logic [AW_RF-1:0] pend_waddr;

  assign accept     = ex_valid && (state == IDLE);
  assign mem_op     = is_load || is_store;
  assign misaligned = (exe_out[1:0] != 2'b00);
  assign start_mem  = accept && mem_op && !misaligned;
  assign fsm_state  = state;

  // Next-state logic: enter MEM on an aligned access, leave on ack or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_mem) state_next = MEM;
      MEM:     if (mem_ack || expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  mem_wb_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_mem),
    .enable ((state == MEM) && !mem_ack),
    .expire (expire)
  );

  // Registered outputs: RF write and redirect pulses, bus request, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ready     <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      br_taken     <= 1'b0;
      br_target    <= '0;
      mem_err      <= 1'b0;
      pend_load_wb <= 1'b0;
      pend_waddr   <= '0;
    end else begin
      rf_we    <= 1'b0;
      br_taken <= 1'b0;
      ex_ready <= (state_next == IDLE);
      if (state == IDLE) begin
        if (accept && mem_op) begin
          if (misaligned) begin
            mem_err <= 1'b1;
          end else begin
            // A load+store combination behaves as a store.
            mem_req      <= 1'b1;
            mem_we       <= is_store;
            mem_addr     <= exe_out;
            mem_wdata    <= store_data;
            pend_load_wb <= is_load && !is_store && needs_wb && (wb_addr != '0);
            pend_waddr   <= wb_addr;
          end
        end else if (accept) begin
          if (needs_wb && (wb_addr != '0)) begin
            rf_we    <= 1'b1;
            rf_waddr <= wb_addr;
            rf_wdata <= is_branch ? (pc_in + DW'(LINK_OFFSET)) : exe_out;
          end
          if (is_branch && z_flag) begin
            br_taken  <= 1'b1;
            br_target <= exe_out;
          end
        end
      end else begin
        // Ack has priority over a timeout expiring in the same cycle.
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (pend_load_wb) begin
            rf_we    <= 1'b1;
            rf_waddr <= pend_waddr;
            rf_wdata <= mem_rdata;
          end
        end else if (expire) begin
          mem_req <= 1'b0;
          mem_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized mix
// checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_wb_stage;
  import proc_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_valid, ex_ready, z_flag, is_branch, is_load, is_store, needs_wb;
  logic [31:0] exe_out, pc_in, store_data, mem_addr, mem_wdata, mem_rdata, rf_wdata, br_target;
  logic [3:0]  wb_addr, rf_waddr;
  logic        mem_req, mem_we, mem_ack, rf_we, br_taken, mem_err;
  state_t      fsm_state;

  int   tests_run = 0, tests_failed = 0;
  logic err_exp = 1'b0;
  logic [35:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  mem_wb_stage #(.DW(32), .AW_RF(4), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .exe_out(exe_out),
    .z_flag(z_flag), .pc_in(pc_in), .is_branch(is_branch), .is_load(is_load), .is_store(is_store),
    .needs_wb(needs_wb), .store_data(store_data), .wb_addr(wb_addr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .br_taken(br_taken), .br_target(br_target), .mem_err(mem_err), .fsm_state(fsm_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; z_flag = 0; is_branch = 0; is_load = 0; is_store = 0; needs_wb = 0;
    exe_out = 0; pc_in = 0; store_data = 0; wb_addr = 0;
  endtask

  task automatic present(input logic [31:0] exe, input logic [31:0] pc, input logic [31:0] sd,
                         input logic [3:0] wa, input logic br, input logic z,
                         input logic ld, input logic st, input logic nwb);
    ex_valid = 1; exe_out = exe; pc_in = pc; store_data = sd; wb_addr = wa;
    is_branch = br; z_flag = z; is_load = ld; is_store = st; needs_wb = nwb;
  endtask

  // Drives one aligned memory access with a given number of wait cycles before ack.
  task automatic mem_txn(input logic [31:0] addr, input logic ld, input logic st,
                         input logic [31:0] sd, input logic [31:0] rd, input int waits,
                         input logic [3:0] wa, input logic nwb);
    logic        wr_exp;
    logic [69:0] hold_exp;
    wr_exp = ld && !st && nwb && (wa != 0);
    present(addr, 32'h0, sd, wa, 1'b0, 1'b0, ld, st, nwb);
    step();
    tests_run++; if ({mem_req, ex_ready, mem_we, mem_addr} !== {1'b1, 1'b0, st, addr}) begin tests_failed++; $display("FAIL mem_start: got req=%0b rdy=%0b we=%0b addr=%h want req=1 rdy=0 we=%0b addr=%h", mem_req, ex_ready, mem_we, mem_addr, st, addr); end
    if (st) begin tests_run++; if (mem_wdata !== sd) begin tests_failed++; $display("FAIL mem_wdata: got %h want %h", mem_wdata, sd); end end
    hold_exp = {1'b1, 1'b0, st, addr, mem_wdata, 1'b0};
    // EXE keeps offering a different op while stalled; it must not be taken.
    present($urandom(), $urandom(), $urandom(), 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < waits; w++) begin
      step();
      tests_run++; if ({mem_req, ex_ready, mem_we, mem_addr, mem_wdata, rf_we} !== hold_exp) begin tests_failed++; $display("FAIL mem_hold: wait %0d req=%0b rdy=%0b addr=%h wdata=%h rf_we=%0b", w, mem_req, ex_ready, mem_addr, mem_wdata, rf_we); end
    end
    mem_ack = 1; mem_rdata = rd;
    step();
    mem_ack = 0; mem_rdata = $urandom(); clear_inputs();
    tests_run++; if ({mem_req, ex_ready, rf_we, mem_err} !== {1'b0, 1'b1, wr_exp, err_exp}) begin tests_failed++; $display("FAIL mem_done: got req=%0b rdy=%0b rf_we=%0b err=%0b want 0 1 %0b %0b", mem_req, ex_ready, rf_we, mem_err, wr_exp, err_exp); end
    if (wr_exp) begin tests_run++; if ({rf_waddr, rf_wdata} !== {wa, rd}) begin tests_failed++; $display("FAIL load_data: got r%0d=%h want r%0d=%h", rf_waddr, rf_wdata, wa, rd); end end
    step();
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL load_pulse: got rf_we=%0b want 0", rf_we); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; clear_inputs(); mem_ack = 0; mem_rdata = 0;
    #22;
    tests_run++; if ({ex_ready, mem_req, mem_we, rf_we, br_taken, mem_err, mem_addr, rf_wdata, br_target} !== {1'b1, 5'b0, 96'h0}) begin tests_failed++; $display("FAIL reset_outputs: got rdy=%0b req=%0b rf_we=%0b br=%0b err=%0b", ex_ready, mem_req, rf_we, br_taken, mem_err); end
    tests_run++; if (fsm_state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want IDLE", fsm_state); end
    @(negedge clk); rst_n = 1;
    step();
  endtask

  task automatic test_alu();
    logic [31:0] d[4];
    logic [3:0]  a[4];
    d[0] = 32'h0000_1234; a[0] = 4'd3;
    d[1] = $urandom();     a[1] = 4'd5;
    d[2] = $urandom();     a[2] = 4'd9;
    d[3] = $urandom();     a[3] = 4'd0;   // r0 is never written
    for (int i = 0; i < 4; i++) begin
      present(d[i], $urandom(), $urandom(), a[i], 1'b0, $urandom_range(0, 1), 1'b0, 1'b0, 1'b1);
      step();
      tests_run++; if ({rf_we, ex_ready, br_taken} !== {(a[i] != 0), 1'b1, 1'b0}) begin tests_failed++; $display("FAIL alu_pulse%0d: got we=%0b rdy=%0b br=%0b want we=%0b", i, rf_we, ex_ready, br_taken, (a[i] != 0)); end
      if (a[i] != 0) begin tests_run++; if ({rf_waddr, rf_wdata} !== {a[i], d[i]}) begin tests_failed++; $display("FAIL alu_data%0d: got r%0d=%h want r%0d=%h", i, rf_waddr, rf_wdata, a[i], d[i]); end end
    end
    present($urandom(), 0, 0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // no write-back
    step();
    clear_inputs();
    tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL alu_nowb: got rf_we=%0b want 0", rf_we); end
    step();
  endtask

  task automatic test_load();
    mem_txn(32'h100, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 3, 4'd7, 1'b1);
  endtask

  task automatic test_store();
    mem_txn(32'h200, 1'b0, 1'b1, 32'hA5A5_A5A5, $urandom(), 1, 4'd4, 1'b1);
    mem_txn(32'h204, 1'b1, 1'b1, $urandom(), $urandom(), 2, 4'd4, 1'b1);   // load+store acts as store
  endtask

  task automatic test_branch();
    present(32'h80, 32'h40, 0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    tests_run++; if ({br_taken, br_target, rf_we, rf_waddr, rf_wdata} !== {1'b1, 32'h80, 1'b1, 4'd15, 32'h44}) begin tests_failed++; $display("FAIL br_taken_link: got br=%0b tgt=%h we=%0b r%0d=%h", br_taken, br_target, rf_we, rf_waddr, rf_wdata); end
    present(32'h80, 32'h40, 0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    tests_run++; if ({br_taken, rf_we, rf_wdata} !== {1'b0, 1'b1, 32'h44}) begin tests_failed++; $display("FAIL br_not_taken_link: got br=%0b we=%0b data=%h", br_taken, rf_we, rf_wdata); end
    present(32'h1000, 32'hFFFF_FFFC, 0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    tests_run++; if ({br_taken, br_target, rf_wdata} !== {1'b1, 32'h1000, 32'h0}) begin tests_failed++; $display("FAIL br_link_wrap: got br=%0b tgt=%h data=%h", br_taken, br_target, rf_wdata); end
    present(32'h3C, 32'h10, 0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    tests_run++; if ({br_taken, br_target, rf_we} !== {1'b1, 32'h3C, 1'b0}) begin tests_failed++; $display("FAIL br_no_link: got br=%0b tgt=%h we=%0b", br_taken, br_target, rf_we); end
    step();
    tests_run++; if (br_taken !== 1'b0) begin tests_failed++; $display("FAIL br_pulse: got br=%0b want 0", br_taken); end
  endtask

  task automatic test_ack_at_expire();
    // Ack arrives on the very cycle the wait limit is reached: access completes cleanly.
    mem_txn(32'h3F0, 1'b1, 1'b0, 0, 32'h1357_9BDF, TO - 1, 4'd12, 1'b1);
  endtask

  task automatic test_misaligned();
    present(32'h102, 0, 0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    clear_inputs();
    err_exp = 1'b1;
    tests_run++; if ({mem_req, ex_ready, rf_we, mem_err} !== 4'b0101) begin tests_failed++; $display("FAIL misaligned: got req=%0b rdy=%0b we=%0b err=%0b want 0 1 0 1", mem_req, ex_ready, rf_we, mem_err); end
    step();
    tests_run++; if (mem_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %0b want 1", mem_err); end
  endtask

  task automatic test_reset_mid_access();
    present(32'h300, 0, 0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    clear_inputs();
    step(); step();
    #2 rst_n = 0;
    #1;
    tests_run++; if ({mem_req, ex_ready, rf_we, mem_err} !== 4'b0100) begin tests_failed++; $display("FAIL reset_mid: got req=%0b rdy=%0b we=%0b err=%0b want 0 1 0 0", mem_req, ex_ready, rf_we, mem_err); end
    @(negedge clk); rst_n = 1; err_exp = 1'b0;
    mem_ack = 1; mem_rdata = $urandom();   // stray ack while idle
    step();
    mem_ack = 0;
    tests_run++; if ({mem_req, ex_ready, rf_we, mem_err} !== 4'b0100) begin tests_failed++; $display("FAIL stray_ack: got req=%0b rdy=%0b we=%0b err=%0b want 0 1 0 0", mem_req, ex_ready, rf_we, mem_err); end
  endtask

  task automatic test_timeout();
    int cycles;
    present(32'h400, 0, 0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    clear_inputs();
    cycles = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      cycles++;
      step();
    end
    err_exp = 1'b1;
    tests_run++; if (cycles !== TO) begin tests_failed++; $display("FAIL timeout_len: got %0d cycles of mem_req want %0d", cycles, TO); end
    tests_run++; if ({mem_req, ex_ready, rf_we, mem_err} !== 4'b0101) begin tests_failed++; $display("FAIL timeout_end: got req=%0b rdy=%0b we=%0b err=%0b want 0 1 0 1", mem_req, ex_ready, rf_we, mem_err); end
  endtask

  task automatic test_random_mix();
    for (int n = 0; n < 40; n++) begin
      int          kind, waits;
      logic [31:0] exe, pc, sd, rd;
      logic [3:0]  wa;
      logic        z, nwb, mis, ld, st, br, br_exp, we_exp;
      kind = $urandom_range(0, 3);
      pc = $urandom(); sd = $urandom(); rd = $urandom();
      wa = 4'($urandom_range(0, 15)); z = 1'($urandom_range(0, 1)); nwb = 1'($urandom_range(0, 1));
      mis = ($urandom_range(0, 7) == 0);
      exe = $urandom() & 32'hFFFF_FFFC;
      ld = (kind == 2); st = (kind == 3); br = (kind == 1);
      if ((ld || st) && mis) exe = exe | 32'h1;
      present(exe, pc, sd, wa, br, z, ld, st, nwb);
      step();
      clear_inputs();
      // Reference model: outcome of one instruction from the stage's rules.
      br_exp = br && z;
      we_exp = nwb && (wa != 0) && !st && !((ld) && mis);
      if (we_exp) exp_q.push_back({wa, (br ? pc + 32'd4 : (ld ? rd : exe))});
      if (ld || st) begin
        if (mis) begin
          err_exp = 1'b1;
          tests_run++; if ({mem_req, rf_we, mem_err} !== {1'b0, 1'b0, err_exp}) begin tests_failed++; $display("FAIL rnd_mis%0d: got req=%0b we=%0b err=%0b", n, mem_req, rf_we, mem_err); end
          continue;
        end
        waits = $urandom_range(0, 5);
        for (int w = 0; w < waits; w++) step();
        tests_run++; if ({mem_req, mem_we, mem_addr} !== {1'b1, st, exe}) begin tests_failed++; $display("FAIL rnd_req%0d: got req=%0b we=%0b addr=%h want 1 %0b %h", n, mem_req, mem_we, mem_addr, st, exe); end
        mem_ack = 1; mem_rdata = rd;
        step();
        mem_ack = 0;
      end
      tests_run++; if ({rf_we, br_taken, ex_ready, mem_req, mem_err} !== {we_exp, br_exp, 1'b1, 1'b0, err_exp}) begin tests_failed++; $display("FAIL rnd_out%0d: got we=%0b br=%0b rdy=%0b req=%0b err=%0b want %0b %0b 1 0 %0b", n, rf_we, br_taken, ex_ready, mem_req, mem_err, we_exp, br_exp, err_exp); end
      if (br_exp) begin tests_run++; if (br_target !== exe) begin tests_failed++; $display("FAIL rnd_tgt%0d: got %h want %h", n, br_target, exe); end end
      if (rf_we && exp_q.size() > 0) begin
        logic [35:0] e;
        e = exp_q.pop_front();
        tests_run++; if ({rf_waddr, rf_wdata} !== e) begin tests_failed++; $display("FAIL rnd_wb%0d: got r%0d=%h want r%0d=%h", n, rf_waddr, rf_wdata, e[35:32], e[31:0]); end
      end
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rnd_missing_writes: got %0d pending want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_ack_at_expire();
    test_misaligned();
    test_reset_mid_access();
    test_timeout();
    test_random_mix();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
